// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: CPU register map and ACTIVE layout.
package irq_pkg;
  localparam int REG_W = 8;

  localparam logic [2:0] IRQ_STATUS = 3'd0;
  localparam logic [2:0] IRQ_MASK   = 3'd1;
  localparam logic [2:0] IRQ_MODE   = 3'd2;
  localparam logic [2:0] IRQ_POL    = 3'd3;
  localparam logic [2:0] IRQ_ACTIVE = 3'd4;
  localparam logic [2:0] IRQ_SWTRIG = 3'd5;

  localparam int ACT_VLD_BIT = 7;
endpackage

// File: rtl/irq_controller_if.sv
// CPU register-bus interface of the interrupt controller.
interface irq_controller_if;
  logic       cs;
  logic       rw;
  logic [2:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (output cs, rw, addr, data_in, input data_out);
  modport slave  (input cs, rw, addr, data_in, output data_out);
endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-set-bit encoder: the lowest source index has the highest priority.
module irq_prio_enc #(
  parameter int NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0] req_i,
  output logic               vld_o,
  output logic [2:0]         idx_o
);
  always_comb begin
    vld_o = |req_i;
    idx_o = '0;
    // Scan downward so the lowest asserted index is written last.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = 3'(i);
    end
  end
endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: synchronise, polarity/edge-level qualify, latch, mask and
// drive a registered active-low IRQ line; small CPU register file on the side.
module irq_controller
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               rst,
  irq_controller_if.slave    bus,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               irqb
);
  logic [NUM_SRC-1:0] sync1_q, sync2_q, prev_q;
  logic [NUM_SRC-1:0] pend_q, pend_d, mask_q, mask_d;
  logic [NUM_SRC-1:0] mode_q, mode_d, pol_q, pol_d;
  logic [REG_W-1:0]   active_q, active_d;
  logic               irqb_q, irqb_d;

  logic [NUM_SRC-1:0] s, set, clr, wdat, req;
  logic               wr, enc_vld;
  logic [2:0]         enc_idx;

  assign s    = sync2_q ^ pol_q;
  assign wr   = bus.cs & ~bus.rw;
  assign wdat = bus.data_in[NUM_SRC-1:0];
  assign req  = pend_q & mask_q;

  irq_prio_enc #(.NUM_SRC(NUM_SRC)) u_enc (
    .req_i (req),
    .vld_o (enc_vld),
    .idx_o (enc_idx)
  );

  always_comb begin
    set = (mode_q & s & ~prev_q) | (~mode_q & s);
    clr = '0;
    if (wr && bus.addr == IRQ_SWTRIG) set = set | wdat;
    if (wr && bus.addr == IRQ_STATUS) clr = wdat;
    // Set is applied after clear so a coincident new event is never lost.
    pend_d = (pend_q & ~clr) | set;

    mask_d = (wr && bus.addr == IRQ_MASK) ? wdat : mask_q;
    mode_d = (wr && bus.addr == IRQ_MODE) ? wdat : mode_q;
    pol_d  = (wr && bus.addr == IRQ_POL)  ? wdat : pol_q;

    active_d              = '0;
    active_d[ACT_VLD_BIT] = enc_vld;
    active_d[2:0]         = enc_idx;
    irqb_d                = ~|req;
  end

  always_comb begin
    bus.data_out = '0;
    if (bus.cs && bus.rw) begin
      case (bus.addr)
        IRQ_STATUS: bus.data_out = REG_W'(pend_q);
        IRQ_MASK:   bus.data_out = REG_W'(mask_q);
        IRQ_MODE:   bus.data_out = REG_W'(mode_q);
        IRQ_POL:    bus.data_out = REG_W'(pol_q);
        IRQ_ACTIVE: bus.data_out = active_q;
        default:    bus.data_out = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      pend_q   <= '0;
      mask_q   <= '0;
      mode_q   <= '0;
      pol_q    <= '0;
      active_q <= '0;
      irqb_q   <= 1'b1;
    end else begin
      sync1_q  <= irq_src;
      sync2_q  <= sync1_q;
      prev_q   <= s;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      mode_q   <= mode_d;
      pol_q    <= pol_d;
      active_q <= active_d;
      irqb_q   <= irqb_d;
    end
  end

  assign irqb = irqb_q;
endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: stimulus pushes expectations, a negedge monitor checks them.
module tb_irq_controller;
  import irq_pkg::*;

  typedef struct {
    string      name;
    bit         is_irq;
    logic [7:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] irq_src = '0;
  logic       irqb;
  logic       chk = 1'b0;
  int         total = 0;
  int         bad = 0;
  exp_t       q[$];

  irq_controller_if bus();

  irq_controller #(.NUM_SRC(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .irq_src (irq_src),
    .irqb    (irqb)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (chk) begin
      exp_t e;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard: check strobe with empty queue");
      end else begin
        e = q.pop_front();
        if (e.is_irq) begin
          if (irqb !== e.val[0]) begin
            bad++;
            $display("FAIL %s: irqb=%b expected %b", e.name, irqb, e.val[0]);
          end
        end else if (bus.data_out !== e.val) begin
          bad++;
          $display("FAIL %s: data_out=0x%02h expected 0x%02h", e.name, bus.data_out, e.val);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus.cs = 1'b1; bus.rw = 1'b0; bus.addr = a; bus.data_in = d;
    step();
    bus.cs = 1'b0; bus.rw = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] e, input string nm);
    q.push_back('{name: nm, is_irq: 1'b0, val: e});
    bus.cs = 1'b1; bus.rw = 1'b1; bus.addr = a;
    chk = 1'b1;
    step();
    chk = 1'b0; bus.cs = 1'b0;
  endtask

  task automatic chk_irqb(input logic e, input string nm);
    q.push_back('{name: nm, is_irq: 1'b1, val: {7'd0, e}});
    chk = 1'b1;
    step();
    chk = 1'b0;
  endtask

  initial begin
    bus.cs = 1'b0; bus.rw = 1'b1; bus.addr = '0; bus.data_in = '0;
    idle(3);
    rst = 1'b0;

    // 1: reset values, masked latch, unmask latency
    for (int a = 0; a < 8; a++) rd(3'(a), 8'h00, $sformatf("reset_reg%0d", a));
    chk_irqb(1'b1, "reset_irqb");
    irq_src = 8'h02; idle(3); irq_src = 8'h00; idle(4);
    rd(IRQ_STATUS, 8'h02, "t1_status_masked");
    chk_irqb(1'b1, "t1_irqb_masked");
    wr(IRQ_MASK, 8'h02);
    chk_irqb(1'b1, "t1_irqb_same_cycle");
    chk_irqb(1'b0, "t1_irqb_unmask");
    rd(IRQ_ACTIVE, 8'h81, "t1_active");
    wr(IRQ_STATUS, 8'h02); wr(IRQ_MASK, 8'h00);

    // 2: level source, sync latency, W1C while held
    wr(IRQ_MODE, 8'h00); wr(IRQ_MASK, 8'h01);
    irq_src = 8'h01; idle(3);
    chk_irqb(1'b1, "t2_irqb_before_n3");
    chk_irqb(1'b0, "t2_irqb_at_n3");
    wr(IRQ_STATUS, 8'h01);
    rd(IRQ_STATUS, 8'h01, "t2_level_reset");
    irq_src = 8'h00; idle(4);
    wr(IRQ_STATUS, 8'h01);
    rd(IRQ_STATUS, 8'h00, "t2_status_clear");
    chk_irqb(1'b1, "t2_irqb_release");
    wr(IRQ_MASK, 8'h00);

    // 3: edge source held high sets once
    wr(IRQ_MODE, 8'h04); wr(IRQ_MASK, 8'h04);
    irq_src = 8'h04; idle(10);
    rd(IRQ_STATUS, 8'h04, "t3_edge_set");
    chk_irqb(1'b0, "t3_irqb_low");
    wr(IRQ_STATUS, 8'h04); idle(80);
    rd(IRQ_STATUS, 8'h00, "t3_held_no_reset");
    chk_irqb(1'b1, "t3_irqb_high");
    irq_src = 8'h00; idle(4);
    rd(IRQ_STATUS, 8'h00, "t3_fall_no_set");
    irq_src = 8'h04; idle(4);
    rd(IRQ_STATUS, 8'h04, "t3_second_rise");
    irq_src = 8'h00; idle(4);
    wr(IRQ_STATUS, 8'h04); wr(IRQ_MASK, 8'h00); wr(IRQ_MODE, 8'h00);

    // 4: active-low edge source (button)
    wr(IRQ_MODE, 8'h01); wr(IRQ_POL, 8'h01);
    irq_src = 8'h01; idle(4);
    rd(IRQ_STATUS, 8'h01, "t4_pol_change_edge");
    wr(IRQ_STATUS, 8'h01); wr(IRQ_MASK, 8'h01);
    rd(IRQ_STATUS, 8'h00, "t4_idle_clear");
    irq_src = 8'h00; idle(4);
    rd(IRQ_STATUS, 8'h01, "t4_press");
    chk_irqb(1'b0, "t4_irqb_press");
    wr(IRQ_STATUS, 8'h01);
    irq_src = 8'h01; idle(4);
    rd(IRQ_STATUS, 8'h00, "t4_release_no_set");
    chk_irqb(1'b1, "t4_irqb_release");
    wr(IRQ_MASK, 8'h00); wr(IRQ_POL, 8'h00);
    irq_src = 8'h00; idle(4);
    wr(IRQ_MODE, 8'h00); wr(IRQ_STATUS, 8'hFF);
    rd(IRQ_STATUS, 8'h00, "t4_cleanup");

    // 5: priority encoding
    irq_src = 8'h48; idle(3); irq_src = 8'h00; idle(4);
    wr(IRQ_MASK, 8'h48); step();
    rd(IRQ_ACTIVE, 8'h83, "t5_active_3");
    chk_irqb(1'b0, "t5_irqb_low");
    wr(IRQ_STATUS, 8'h08); step();
    rd(IRQ_ACTIVE, 8'h86, "t5_active_6");
    wr(IRQ_STATUS, 8'h40); step();
    rd(IRQ_ACTIVE, 8'h00, "t5_active_none");
    chk_irqb(1'b1, "t5_irqb_high");
    wr(IRQ_MASK, 8'h00);

    // 6: set-wins collision, SWTRIG, reset
    wr(IRQ_MODE, 8'h20);
    irq_src = 8'h20; step(); step();
    wr(IRQ_STATUS, 8'h20);
    rd(IRQ_STATUS, 8'h20, "t6_set_wins");
    wr(IRQ_STATUS, 8'h20);
    rd(IRQ_STATUS, 8'h00, "t6_w1c_after");
    irq_src = 8'h00; idle(3);
    wr(IRQ_SWTRIG, 8'h80); wr(IRQ_MASK, 8'h80); step();
    chk_irqb(1'b0, "t6_swtrig_irqb");
    rd(IRQ_STATUS, 8'h80, "t6_swtrig_status");
    rd(IRQ_SWTRIG, 8'h00, "t6_swtrig_reads0");
    rd(IRQ_ACTIVE, 8'h87, "t6_active_7");
    rst = 1'b1; step(); rst = 1'b0;
    chk_irqb(1'b1, "t6_rst_irqb");
    for (int a = 0; a < 5; a++) rd(3'(a), 8'h00, $sformatf("t6_rst_reg%0d", a));

    idle(2);
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
